// File: rtl/logic16_pkg.sv
// Shared definitions for the 16-bit logic-unit arbiter: data width, opcodes
// and FSM state encoding.
package logic16_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/And16.sv
// 16-bit bitwise AND gate used as the AND path of the shared logic unit.
module And16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = a & b;

endmodule

// File: rtl/logic16_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ, found by searching a doubled copy of the request vector.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int ID_W = $clog2(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic               found;

  assign dbl = {req, req};

  // Window [ptr, ptr+N_REQ) of the doubled vector covers every index exactly once.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < 2*N_REQ; j++) begin
      if (!found && dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + N_REQ)) begin
        found = 1'b1;
        idx   = (j >= N_REQ) ? ID_W'(j - N_REQ) : ID_W'(j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = found && (idx == ID_W'(i));
    end
  end

  assign any = found;

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one 16-bit AND/OR/XOR/NAND unit among N_REQ
// requesters, one operation in flight, valid/ready response port.
module logic16_arbiter
  import logic16_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int OP_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [2*N_REQ-1:0]       req_op,
  input  logic [DATA_W*N_REQ-1:0]  req_a,
  input  logic [DATA_W*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (OP_LAT > 1) ? $clog2(OP_LAT) : 1;

  state_t state, state_d;

  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [ID_W-1:0]   id_q;

  logic [N_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;

  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [DATA_W-1:0] and_y, result;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grants only exist while idle; reset also forces them low.
  assign gnt  = (state == S_IDLE && !rst) ? pick_gnt : '0;
  assign busy = (state != S_IDLE);

  always_comb begin
    sel_op = OP_AND;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[DATA_W*i +: DATA_W];
        sel_b  = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  And16 u_and (
    .a (a_q),
    .b (b_q),
    .y (and_y)
  );

  always_comb begin
    result = and_y;
    case (op_q)
      OP_AND:  result = and_y;
      OP_OR:   result = a_q | b_q;
      OP_XOR:  result = a_q ^ b_q;
      default: result = ~(a_q & b_q);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (pick_any) state_d = S_EXEC;
      S_EXEC:  if (cnt == '0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture on the grant edge; the response registers stay frozen through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= '0;
      op_q      <= OP_AND;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            op_q <= sel_op;
            a_q  <= sel_a;
            b_q  <= sel_b;
            id_q <= pick_idx;
            ptr  <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            cnt  <= CNT_W'(OP_LAT - 1);
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            rsp_data  <= result;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed bench for logic16_arbiter: expected responses are queued at grant
// time and a monitor compares them at each response handshake.
module tb_logic16_arbiter;
  import logic16_pkg::*;

  localparam int N = 4;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [2*N-1:0] req_op;
  logic [16*N-1:0] req_a, req_b;
  logic [N-1:0]  gnt;
  logic          rsp_valid, rsp_ready;
  logic [15:0]   rsp_data;
  logic [1:0]    rsp_id;
  logic          busy;

  logic [N-1:0]  req_valid3;
  logic [2*N-1:0] req_op3;
  logic [16*N-1:0] req_a3, req_b3;
  logic [N-1:0]  gnt3;
  logic          rsp_valid3, rsp_ready3;
  logic [15:0]   rsp_data3;
  logic [1:0]    rsp_id3;
  logic          busy3;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  logic16_arbiter #(.N_REQ(N), .OP_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  logic16_arbiter #(.N_REQ(N), .OP_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_op(req_op3),
    .req_a(req_a3), .req_b(req_b3), .gnt(gnt3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_id(rsp_id3), .busy(busy3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req_valid[idx]      = 1'b1;
    req_op[2*idx +: 2]  = op;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  task automatic clearReq();
    req_valid = '0;
  endtask

  task automatic pushExp(input logic [1:0] id, input logic [15:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || rsp_valid) && n < 20) begin
      step(); #1; n++;
    end
    checkOutput(name, busy, 0);
  endtask

  // Scoreboard monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_rsp", rsp_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_data", rsp_data, e.data);
        checkOutput("rsp_id", rsp_id, e.id);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] t2_data [4];
    int          t2_order [5];
    logic [3:0]  exp_g;
    int          t, last_t, lat;

    t2_data[0] = 16'h3030; t2_data[1] = 16'h1234;
    t2_data[2] = 16'hFF00; t2_data[3] = 16'h0FFF;
    t2_order[0] = 0; t2_order[1] = 1; t2_order[2] = 2; t2_order[3] = 3; t2_order[4] = 0;

    rst = 1'b1; rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_valid3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0;

    step(); step(); #1;
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_busy", busy, 0);
    step(); rst = 1'b0;

    // Single AND request: grant same cycle, response two cycles later
    step(); applyStimulus(0, OP_AND, 16'h0001, 16'h0000); #1;
    checkOutput("t1_gnt", gnt, 4'b0001);
    pushExp(2'd0, 16'h0000);
    step(); clearReq(); #1;
    checkOutput("t1_exec_rsp_valid", rsp_valid, 0);
    checkOutput("t1_exec_busy", busy, 1);
    checkOutput("t1_exec_gnt", gnt, 0);
    step(); #1;
    checkOutput("t1_rsp_valid", rsp_valid, 1);
    step(); #1;
    checkOutput("t1_idle_busy", busy, 0);

    // All four requesting continuously: order 0,1,2,3,0 spaced by 3 cycles
    step(); rst = 1'b1; #1;
    step(); rst = 1'b0;
    step();
    applyStimulus(0, OP_AND,  16'hF0F0, 16'h3C3C);
    applyStimulus(1, OP_OR,   16'h1200, 16'h0034);
    applyStimulus(2, OP_XOR,  16'hFFFF, 16'h00FF);
    applyStimulus(3, OP_NAND, 16'hF0F0, 16'hFF00);
    #1;
    t = 0; last_t = 0;
    for (int k = 0; k < 5; k++) begin
      int waited = 0;
      while (gnt == '0 && waited < 10) begin
        step(); #1; t++; waited++;
      end
      exp_g = 4'(1 << t2_order[k]);
      checkOutput("t2_gnt_order", gnt, exp_g);
      if (k > 0) checkOutput("t2_gnt_spacing", t - last_t, 3);
      pushExp(2'(t2_order[k]), t2_data[t2_order[k]]);
      last_t = t;
      step(); #1; t++;
    end
    clearReq();
    waitIdle("t2_drain");

    // Backpressure: response held stable, no grants while stalled
    rsp_ready = 1'b0;
    step(); applyStimulus(2, OP_XOR, 16'hA5A5, 16'hFFFF); #1;
    checkOutput("t4_gnt", gnt, 4'b0100);
    pushExp(2'd2, 16'h5A5A);
    step(); clearReq(); applyStimulus(0, OP_AND, 16'hFFFF, 16'h00FF); #1;
    checkOutput("t4_exec_gnt", gnt, 0);
    step(); #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4_hold_valid", rsp_valid, 1);
      checkOutput("t4_hold_data", rsp_data, 16'h5A5A);
      checkOutput("t4_hold_id", rsp_id, 2);
      checkOutput("t4_hold_gnt", gnt, 0);
      checkOutput("t4_hold_busy", busy, 1);
      step(); #1;
    end
    rsp_ready = 1'b1;
    step(); #1;
    checkOutput("t4_release_busy", busy, 0);
    checkOutput("t4_release_gnt", gnt, 4'b0001);
    pushExp(2'd0, 16'h00FF);
    step(); clearReq();
    waitIdle("t4_drain");

    // Wrap: grant to 3, then with 1 and 3 pending the pointer wraps to 1
    step(); applyStimulus(3, OP_NAND, 16'h0000, 16'h0000); #1;
    checkOutput("t5_gnt3", gnt, 4'b1000);
    pushExp(2'd3, 16'hFFFF);
    step(); clearReq();
    waitIdle("t5_drain_a");
    step();
    applyStimulus(1, OP_OR,   16'h0F00, 16'h00F0);
    applyStimulus(3, OP_NAND, 16'h1234, 16'h1234);
    #1;
    checkOutput("t5_gnt_wrap", gnt, 4'b0010);
    pushExp(2'd1, 16'h0FF0);
    step(); clearReq();
    waitIdle("t5_drain_b");

    // Reset during EXEC aborts the operation and returns the pointer to 0
    step(); applyStimulus(2, OP_AND, 16'hFFFF, 16'hFFFF); #1;
    checkOutput("t6_gnt", gnt, 4'b0100);
    step(); clearReq(); #1;
    checkOutput("t6_exec_busy", busy, 1);
    rst = 1'b1; #1;
    checkOutput("t6_rst_rsp_valid", rsp_valid, 0);
    checkOutput("t6_rst_rsp_data", rsp_data, 0);
    checkOutput("t6_rst_busy", busy, 0);
    step(); rst = 1'b0;
    step();
    applyStimulus(3, OP_AND, 16'hFFFF, 16'hFFFF);
    applyStimulus(1, OP_XOR, 16'h0000, 16'h1111);
    #1;
    checkOutput("t6_gnt_lowest", gnt, 4'b0010);
    pushExp(2'd1, 16'h1111);
    step(); clearReq();
    waitIdle("t6_drain");

    // OP_LAT=3 instance: response appears 4 cycles after the grant cycle
    step();
    req_valid3[0] = 1'b1; req_op3[1:0] = OP_AND;
    req_a3[15:0] = 16'h1234; req_b3[15:0] = 16'hFFFF;
    #1;
    checkOutput("lat3_gnt", gnt3, 4'b0001);
    step(); req_valid3 = '0; #1;
    lat = 1;
    while (!rsp_valid3 && lat < 20) begin
      step(); #1; lat++;
    end
    checkOutput("lat3_rsp_cycle", lat, 4);
    checkOutput("lat3_rsp_data", rsp_data3, 16'h1234);
    checkOutput("lat3_rsp_id", rsp_id3, 0);
    step(); step(); #1;
    checkOutput("lat3_idle_busy", busy3, 0);

    step(); step(); #3;
    checkOutput("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
